// File: rtl/pipe_register_elastic.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshakes.
// Bubbles collapse; optional input skid makes the upstream ready a flop.
module pipe_register_elastic #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int REG_READY  = 0,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_count
);

    logic [DEPTH-1:0]                 v;
    logic [DEPTH-1:0]                 v_nxt;
    logic [DEPTH-1:0]                 acc;
    logic [DEPTH-1:0]                 adv;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] d_nxt;

    logic                  sv;
    logic                  sv_nxt;
    logic [DATA_WIDTH-1:0] sd;
    logic [DATA_WIDTH-1:0] sd_nxt;

    logic                  use_skid;
    logic                  src_v;
    logic [DATA_WIDTH-1:0] src_d;

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    // Advance chain resolved from the output end back to stage 0.
    always_comb begin
        acc = '0;
        adv = '0;
        adv[DEPTH-1] = v[DEPTH-1] & i_ready & ~i_flush;
        acc[DEPTH-1] = ~v[DEPTH-1] | adv[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = v[k] & acc[k+1];
            acc[k] = ~v[k] | adv[k];
        end
    end

    assign use_skid = (REG_READY != 0) && sv;
    assign src_v    = use_skid | i_valid;
    assign src_d    = use_skid ? sd : i_data;

    generate
        if (REG_READY != 0) begin : g_ready_reg
            assign o_ready = ~sv & ~i_flush;
        end else begin : g_ready_comb
            assign o_ready = acc[0] & ~i_flush;
        end
    endgenerate

    assign o_valid = v[DEPTH-1] & ~i_flush;
    assign o_data  = d[DEPTH-1];
    assign o_count = cnt;

    always_comb begin
        v_nxt  = v;
        d_nxt  = d;
        sv_nxt = sv;
        sd_nxt = sd;

        if (acc[0]) begin
            v_nxt[0] = src_v;
            if (src_v) begin
                d_nxt[0] = src_d;
            end
        end

        for (int k = 1; k < DEPTH; k++) begin
            if (acc[k]) begin
                v_nxt[k] = v[k-1];
                if (v[k-1]) begin
                    d_nxt[k] = d[k-1];
                end
            end
        end

        // Skid holds an accepted word that stage 0 could not take.
        if (REG_READY != 0) begin
            if (sv) begin
                if (acc[0]) begin
                    sv_nxt = 1'b0;
                end
            end else if (i_valid & ~i_flush & ~acc[0]) begin
                sv_nxt = 1'b1;
                sd_nxt = i_data;
            end
        end

        if (i_flush) begin
            v_nxt  = '0;
            sv_nxt = 1'b0;
        end

        cnt_nxt = CNT_WIDTH'(sv_nxt);
        for (int k = 0; k < DEPTH; k++) begin
            cnt_nxt = cnt_nxt + CNT_WIDTH'(v_nxt[k]);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            v   <= '0;
            d   <= '0;
            sv  <= 1'b0;
            sd  <= '0;
            cnt <= '0;
        end else begin
            v   <= v_nxt;
            d   <= d_nxt;
            sv  <= sv_nxt;
            sd  <= sd_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_register_elastic.sv
// Bench for pipe_register_elastic: three configurations checked every
// cycle against a position-queue model, plus hand-computed expectations.
module tb_pipe_register_elastic;

    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    logic        iv[3];
    logic        ird[3];
    logic        ifl[3];
    logic [31:0] id[3];
    logic        ov[3];
    logic        ordy[3];
    logic [31:0] od[3];
    logic [2:0]  oc0;
    logic [2:0]  oc1;
    logic [1:0]  oc2;

    pipe_register_elastic #(.DATA_WIDTH(32), .DEPTH(3), .REG_READY(0)) u0 (
        .clk(clk), .arst(arst), .i_flush(ifl[0]), .i_valid(iv[0]),
        .o_ready(ordy[0]), .i_data(id[0]), .o_valid(ov[0]),
        .i_ready(ird[0]), .o_data(od[0]), .o_count(oc0)
    );
    pipe_register_elastic #(.DATA_WIDTH(32), .DEPTH(4), .REG_READY(0)) u1 (
        .clk(clk), .arst(arst), .i_flush(ifl[1]), .i_valid(iv[1]),
        .o_ready(ordy[1]), .i_data(id[1]), .o_valid(ov[1]),
        .i_ready(ird[1]), .o_data(od[1]), .o_count(oc1)
    );
    pipe_register_elastic #(.DATA_WIDTH(32), .DEPTH(2), .REG_READY(1)) u2 (
        .clk(clk), .arst(arst), .i_flush(ifl[2]), .i_valid(iv[2]),
        .o_ready(ordy[2]), .i_data(id[2]), .o_valid(ov[2]),
        .i_ready(ird[2]), .o_data(od[2]), .o_count(oc2)
    );

    int dep[3] = '{3, 4, 2};
    int rr[3]  = '{0, 0, 1};

    int ncmp = 0;
    int nbad = 0;
    int cyc  = 0;

    // Model: each held word has a position; -1 is the skid slot,
    // DEPTH-1 is the output stage, DEPTH means it left this cycle.
    int          mp[3][8];
    logic [31:0] md[3][8];
    int          mn[3];
    int          np[3][8];
    int          cand[3];
    bit          erdy[3];
    bit          evld[3];

    logic [31:0] src[3][32];
    int          sh[3];
    int          st[3];
    int          gap[3];
    int          gcnt[3];

    logic [31:0] olog[3][32];
    int          on[3];

    bit lat_arm = 1'b0;
    int acc_cyc = -1;
    int lat = -1;
    bit pk_arm = 1'b0;
    int pk = 0;
    int b0;
    int b1;
    int b2;

    function automatic int cnt_of(input int i);
        case (i)
            0:       return int'(oc0);
            1:       return int'(oc1);
            default: return int'(oc2);
        endcase
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s u%0d: got %0h, want %0h (t=%0t)",
                     nm, i, act, exp, $time);
        end
    endtask

    task automatic predict(input int i);
        int p;
        int nx;
        p = ird[i] ? dep[i] + 1 : dep[i];
        for (int j = 0; j < mn[i]; j++) begin
            nx = mp[i][j] + 1;
            np[i][j] = (nx < p - 1) ? nx : p - 1;
            p = np[i][j];
        end
        cand[i] = (p - 1 < 0) ? p - 1 : 0;
        if (rr[i] != 0)
            erdy[i] = !ifl[i] && !(mn[i] > 0 && mp[i][mn[i]-1] == -1);
        else
            erdy[i] = !ifl[i] && cand[i] == 0;
        evld[i] = !ifl[i] && mn[i] > 0 && mp[i][0] == dep[i] - 1;
    endtask

    task automatic push(input int i, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            src[i][st[i]] = base + 32'(k + 1);
            st[i]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (sh[i] < st[i] && gcnt[i] == 0) begin
                iv[i] = 1'b1;
                id[i] = src[i][sh[i]];
            end else begin
                iv[i] = 1'b0;
                id[i] = '0;
            end
        end
    endtask

    task automatic sample();
        #2;
        for (int i = 0; i < 3; i++) begin
            predict(i);
            chk("ready", i, 32'(ordy[i]), 32'(erdy[i]));
            chk("valid", i, 32'(ov[i]), 32'(evld[i]));
            chk("count", i, 32'(cnt_of(i)), 32'(mn[i]));
            if (evld[i]) chk("data", i, od[i], md[i][0]);
        end
        if (lat_arm && acc_cyc >= 0 && lat < 0 && ov[0]) lat = cyc - acc_cyc;
        if (pk_arm && int'(oc0) > pk) pk = int'(oc0);
    endtask

    task automatic clk_edge();
        bit accd[3];
        int m;
        for (int i = 0; i < 3; i++) begin
            accd[i] = !arst && iv[i] && erdy[i];
            if (!arst && evld[i] && ird[i]) begin
                olog[i][on[i]] = md[i][0];
                on[i]++;
            end
        end
        if (lat_arm && acc_cyc < 0 && accd[0]) acc_cyc = cyc;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (arst || ifl[i]) begin
                mn[i] = 0;
            end else begin
                m = 0;
                for (int j = 0; j < mn[i]; j++) begin
                    if (np[i][j] != dep[i]) begin
                        mp[i][m] = np[i][j];
                        md[i][m] = md[i][j];
                        m++;
                    end
                end
                if (accd[i]) begin
                    mp[i][m] = cand[i];
                    md[i][m] = id[i];
                    m++;
                end
                mn[i] = m;
            end
            if (accd[i]) begin
                sh[i]++;
                gcnt[i] = gap[i];
            end else if (!iv[i] && gcnt[i] > 0) begin
                gcnt[i]--;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            sample();
            clk_edge();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ird[i] = 1'b1; ifl[i] = 1'b0; id[i] = '0;
            mn[i] = 0; sh[i] = 0; st[i] = 0; gap[i] = 0; gcnt[i] = 0;
            on[i] = 0;
        end

        #1 arst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_data", i, od[i], 32'd0);
            chk("rst_count", i, 32'(cnt_of(i)), 32'd0);
            chk("rst_ready", i, 32'(ordy[i]), 32'd1);
        end
        @(negedge clk);
        arst = 1'b0;
        run(2);

        // Back-to-back stream through DEPTH=3
        lat_arm = 1'b1; acc_cyc = -1; lat = -1; pk_arm = 1'b1; pk = 0;
        push(0, 32'hA5A5_0000, 5);
        run(10);
        lat_arm = 1'b0; pk_arm = 1'b0;
        chk("s1_latency", 0, 32'(lat), 32'd3);
        chk("s1_peak", 0, 32'(pk), 32'd3);
        for (int k = 0; k < 5; k++)
            chk("s1_order", 0, olog[0][k], 32'hA5A5_0001 + 32'(k));

        // Fill under back-pressure, then drain
        b0 = on[0];
        ird[0] = 1'b0;
        push(0, 32'hB000_0000, 5);
        run(6);
        drive(); sample();
        chk("s2_full_ready", 0, 32'(ordy[0]), 32'd0);
        chk("s2_full_count", 0, 32'(oc0), 32'd3);
        clk_edge();
        ird[0] = 1'b1;
        run(10);
        for (int k = 0; k < 5; k++)
            chk("s2_order", 0, olog[0][b0+k], 32'hB000_0001 + 32'(k));

        // Gapped input on DEPTH=4 collapses bubbles
        b1 = on[1];
        ird[1] = 1'b0; gap[1] = 1;
        push(1, 32'hC000_0000, 5);
        run(12);
        drive(); sample();
        chk("s3_full_count", 1, 32'(oc1), 32'd4);
        chk("s3_full_ready", 1, 32'(ordy[1]), 32'd0);
        clk_edge();
        ird[1] = 1'b1;
        run(14);
        gap[1] = 0;
        for (int k = 0; k < 5; k++)
            chk("s3_order", 1, olog[1][b1+k], 32'hC000_0001 + 32'(k));

        // Registered-ready variant fills stages plus skid
        b2 = on[2];
        ird[2] = 1'b0;
        push(2, 32'hD000_0000, 5);
        run(6);
        drive(); sample();
        chk("s4_full_count", 2, 32'(oc2), 32'd3);
        chk("s4_full_ready", 2, 32'(ordy[2]), 32'd0);
        clk_edge();
        ird[2] = 1'b1;
        run(12);
        for (int k = 0; k < 5; k++)
            chk("s4_order", 2, olog[2][b2+k], 32'hD000_0001 + 32'(k));

        // Flush with both handshakes requested
        ird[0] = 1'b0;
        push(0, 32'hF000_0000, 2);
        run(4);
        push(0, 32'hF000_0002, 1);
        ird[0] = 1'b1; ifl[0] = 1'b1;
        drive(); sample();
        chk("s5_flush_valid", 0, 32'(ov[0]), 32'd0);
        chk("s5_flush_ready", 0, 32'(ordy[0]), 32'd0);
        clk_edge();
        ifl[0] = 1'b0;
        drive(); sample();
        chk("s5_post_count", 0, 32'(oc0), 32'd0);
        chk("s5_post_valid", 0, 32'(ov[0]), 32'd0);
        clk_edge();
        run(8);

        // Asynchronous reset mid-stream
        ird[0] = 1'b0;
        push(0, 32'hE000_0000, 3);
        run(5);
        drive(); sample();
        chk("s6_pre_count", 0, 32'(oc0), 32'd3);
        arst = 1'b1;
        #1;
        chk("s6_rst_valid", 0, 32'(ov[0]), 32'd0);
        chk("s6_rst_data", 0, od[0], 32'd0);
        chk("s6_rst_count", 0, 32'(oc0), 32'd0);
        clk_edge();
        arst = 1'b0;
        b0 = on[0];
        ird[0] = 1'b1;
        push(0, 32'hE100_0000, 3);
        run(10);
        for (int k = 0; k < 3; k++)
            chk("s6_order", 0, olog[0][b0+k], 32'hE100_0001 + 32'(k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
